// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: row drive, column synchroniser,
// press/release debounce and one-cycle key / clear strobes.
module keypad_scanner #(
  parameter int SCAN_DIVIDE    = 1000,
  parameter int DEBOUNCE_COUNT = 4,
  parameter int DIV_WIDTH      = $clog2(SCAN_DIVIDE),
  parameter int DEB_WIDTH      = $clog2(DEBOUNCE_COUNT + 1)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key,
  output logic       key_clear,
  output logic       key_held
);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    EMIT     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_LAST   = DIV_WIDTH'(SCAN_DIVIDE - 1);
  localparam logic [DEB_WIDTH-1:0] DEB_TARGET = DEB_WIDTH'(DEBOUNCE_COUNT);
  localparam logic [DEB_WIDTH-1:0] DEB_ONE    = DEB_WIDTH'(1);

  function automatic logic is_single(input logic [3:0] c);
    logic [3:0] low;
    low = ~c;
    return (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] c);
    case (c)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] row_drive(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

  state_t               state;
  logic [3:0]           meta;
  logic [3:0]           cs;
  logic [1:0]           row;
  logic [1:0]           cap_col;
  logic [DIV_WIDTH-1:0] div;
  logic [DEB_WIDTH-1:0] deb;

  logic                 sample;
  logic                 single;
  logic                 none;
  logic [1:0]           col;
  logic [1:0]           next_row;
  logic [DEB_WIDTH-1:0] deb_inc;
  logic                 emit_clear;
  logic [3:0]           emit_code;

  assign sample   = (div == DIV_LAST);
  assign single   = is_single(cs);
  assign none     = (cs == 4'b1111);
  assign col      = col_index(cs);
  assign next_row = row + 2'd1;
  assign deb_inc  = deb + DEB_ONE;
  // The row is held while debouncing, so the live row/column is the captured key.
  assign emit_clear = (row == 2'd3) && (col == 2'd3);
  assign emit_code  = {row, col} + 4'd1;

  // Two-flop synchroniser for the asynchronous column inputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= 4'b1111;
      cs   <= 4'b1111;
    end else begin
      meta <= col_n;
      cs   <= meta;
    end
  end

  // Scan / debounce / emit / release state machine with registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      row       <= 2'd0;
      row_n     <= 4'b1110;
      div       <= '0;
      deb       <= '0;
      cap_col   <= 2'd0;
      key       <= 4'd0;
      key_clear <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key       <= 4'd0;
      key_clear <= 1'b0;
      div       <= sample ? '0 : div + DIV_WIDTH'(1);
      case (state)
        SCAN: begin
          if (sample) begin
            if (single) begin
              cap_col <= col;
              deb     <= DEB_ONE;
              if (DEB_TARGET == DEB_ONE) begin
                state     <= EMIT;
                key       <= emit_clear ? 4'd0 : emit_code;
                key_clear <= emit_clear;
                key_held  <= 1'b1;
              end else begin
                state <= DEBOUNCE;
              end
            end else begin
              row   <= next_row;
              row_n <= row_drive(next_row);
            end
          end
        end
        DEBOUNCE: begin
          if (sample) begin
            if (single && (col == cap_col)) begin
              deb <= deb_inc;
              if (deb_inc == DEB_TARGET) begin
                state     <= EMIT;
                key       <= emit_clear ? 4'd0 : emit_code;
                key_clear <= emit_clear;
                key_held  <= 1'b1;
              end
            end else begin
              state <= SCAN;
              deb   <= '0;
              row   <= next_row;
              row_n <= row_drive(next_row);
            end
          end
        end
        EMIT: begin
          state <= RELEASE;
          deb   <= '0;
        end
        RELEASE: begin
          if (sample) begin
            if (none) begin
              deb <= deb_inc;
              if (deb_inc == DEB_TARGET) begin
                state    <= SCAN;
                deb      <= '0;
                key_held <= 1'b0;
                row      <= next_row;
                row_n    <= row_drive(next_row);
              end
            end else begin
              deb <= '0;
            end
          end
        end
        default: begin
          state <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives col_n from row_n,
// and a scoreboard of expected (code, clear, cycle) pulses is checked by a monitor.
module tb_keypad_scanner;

  logic       clock;
  logic       reset;
  logic [3:0] col_n;
  logic [3:0] row_n;
  logic [3:0] key;
  logic       key_clear;
  logic       key_held;

  logic [3:0][3:0] pressed;
  int checks = 0;
  int errors = 0;
  int cyc;

  typedef struct {
    logic [3:0] code;
    logic       clr;
    int         cyc;
  } ev_t;
  ev_t exp_q[$];
  ev_t mon_e;

  keypad_scanner #(.SCAN_DIVIDE(4), .DEBOUNCE_COUNT(3)) dut (
    .clock    (clock),
    .reset    (reset),
    .col_n    (col_n),
    .row_n    (row_n),
    .key      (key),
    .key_clear(key_clear),
    .key_held (key_held)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Rising edges since reset was released; sample points fall on multiples of 4.
  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Keypad matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && pressed[r][c]) col_n[c] = 1'b0;
  end

  // Scoreboard monitor: every pulse must match the oldest expected entry.
  always @(negedge clock) begin
    if (reset && (key != 4'd0 || key_clear)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: key=%0d key_clear=%0b at cycle %0d, required no pulse", key, key_clear, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (key !== mon_e.code || key_clear !== mon_e.clr || cyc !== mon_e.cyc) begin
          errors++;
          $display("FAIL pulse: key=%0d key_clear=%0b cycle=%0d, required key=%0d key_clear=%0b cycle=%0d",
                   key, key_clear, cyc, mon_e.code, mon_e.clr, mon_e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic step_until(input int target);
    while (cyc < target) step();
  endtask

  task automatic wait_row(input logic [3:0] target, output int at_cyc);
    int n;
    n = 0;
    while (row_n !== target && n < 100) begin
      step();
      n++;
    end
    at_cyc = cyc;
    if (row_n !== target) begin
      checks++;
      errors++;
      $display("FAIL wait_row: row_n=%b, required %b within 100 cycles", row_n, target);
    end
  endtask

  task automatic wait_unheld();
    int n;
    n = 0;
    while (key_held !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    if (key_held !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL wait_unheld: key_held=%b, required 0 within 200 cycles", key_held);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_row;
    reset   = 1'b0;
    pressed = '0;
    repeat (3) step();
    checks++;
    if ({row_n, key, key_clear, key_held} !== {4'b1110, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: row_n=%b key=%0d clr=%b held=%b, required 1110 0 0 0", row_n, key, key_clear, key_held);
    end
    reset = 1'b1;
    for (int n = 0; n < 20; n++) begin
      exp_row = ~(4'b0001 << ((n / 4) % 4));
      checks++;
      if (row_n !== exp_row) begin
        errors++;
        $display("FAIL idle_scan: cycle %0d row_n=%b, required %b", n, row_n, exp_row);
      end
      step();
    end
  endtask

  task automatic test_single_press();
    int p, t, s1, bad;
    wait_row(4'b1110, p);
    pressed[1][2] = 1'b1;
    wait_row(4'b1101, p);
    exp_q.push_back('{code: 4'd7, clr: 1'b0, cyc: p + 12});
    step_until(p + 12);
    bad = 0;
    for (int i = 0; i < 180; i++) begin
      if (key_held !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_hold: held-low cycles=%0d pending pulses=%0d, required 0 and 0", bad, exp_q.size());
    end
    t = cyc;
    pressed = '0;
    s1 = ((t + 6) / 4) * 4;
    step_until(s1 + 7);
    checks++;
    if (key_held !== 1'b1) begin
      errors++;
      $display("FAIL single_release_early: key_held=%b at cycle %0d, required 1", key_held, cyc);
    end
    step();
    checks++;
    if (key_held !== 1'b0) begin
      errors++;
      $display("FAIL single_release: key_held=%b at cycle %0d, required 0", key_held, cyc);
    end
    repeat (40) step();
  endtask

  task automatic test_bounce();
    int p;
    wait_row(4'b0111, p);
    pressed[0][0] = 1'b1;
    wait_row(4'b1110, p);
    step_until(p + 4);
    pressed[0][0] = 1'b0;
    step_until(p + 8);
    pressed[0][0] = 1'b1;
    exp_q.push_back('{code: 4'd1, clr: 1'b0, cyc: p + 32});
    step_until(p + 33);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bounce_pulse: pending pulses=%0d at cycle %0d, required 0", exp_q.size(), cyc);
    end
    pressed = '0;
    wait_unheld();
  endtask

  task automatic test_chord();
    logic [3:0] seen;
    int bad;
    seen = 4'b0000;
    bad  = 0;
    pressed[2][0] = 1'b1;
    pressed[2][1] = 1'b1;
    for (int i = 0; i < 64; i++) begin
      seen = seen | ~row_n;
      if (key_held !== 1'b0 || key !== 4'd0 || key_clear !== 1'b0) bad++;
      step();
    end
    checks++;
    if (seen !== 4'b1111 || bad != 0) begin
      errors++;
      $display("FAIL chord: rows seen=%b bad cycles=%0d, required 1111 and 0", seen, bad);
    end
    pressed = '0;
    repeat (8) step();
  endtask

  task automatic test_clear_key();
    int p, t, s1, bad;
    wait_row(4'b1011, p);
    pressed[3][3] = 1'b1;
    wait_row(4'b0111, p);
    exp_q.push_back('{code: 4'd0, clr: 1'b1, cyc: p + 12});
    step_until(p + 12);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (key_held !== 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL clear_hold: held-low cycles=%0d pending pulses=%0d, required 0 and 0", bad, exp_q.size());
    end
    t = cyc;
    pressed = '0;
    s1 = ((t + 6) / 4) * 4;
    step_until(s1 + 7);
    checks++;
    if (key_held !== 1'b1) begin
      errors++;
      $display("FAIL clear_release_early: key_held=%b at cycle %0d, required 1", key_held, cyc);
    end
    step();
    checks++;
    if (key_held !== 1'b0) begin
      errors++;
      $display("FAIL clear_release: key_held=%b at cycle %0d, required 0", key_held, cyc);
    end
  endtask

  task automatic test_reset_mid_release();
    int p;
    wait_row(4'b1110, p);
    pressed[1][2] = 1'b1;
    wait_row(4'b1101, p);
    exp_q.push_back('{code: 4'd7, clr: 1'b0, cyc: p + 12});
    step_until(p + 20);
    checks++;
    if (exp_q.size() != 0 || key_held !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: pending=%0d key_held=%b, required 0 and 1", exp_q.size(), key_held);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({row_n, key, key_clear, key_held} !== {4'b1110, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: row_n=%b key=%0d clr=%b held=%b, required 1110 0 0 0", row_n, key, key_clear, key_held);
    end
    step();
    step();
    reset = 1'b1;
    exp_q.push_back('{code: 4'd7, clr: 1'b0, cyc: 16});
    step_until(17);
    checks++;
    if (exp_q.size() != 0 || key_held !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_pulse: pending=%0d key_held=%b, required 0 and 1", exp_q.size(), key_held);
    end
    pressed = '0;
    wait_unheld();
  endtask

  initial begin
    reset   = 1'b0;
    pressed = '0;
    test_reset();
    test_single_press();
    test_bounce();
    test_chord();
    test_clear_key();
    test_reset_mid_release();
    repeat (20) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: pending=%0d, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
